// File: rtl/dram_write_burst_gather_if.sv
// AXI write-path channel bundle (AW, W, B) shared by the upstream and downstream sides
// of the write burst gather stage.
interface dram_write_burst_gather_if #(
  parameter int unsigned BW_ADDR    = 32,
  parameter int unsigned BW_DATA    = 128,
  parameter int unsigned BW_AXI_TID = 16
);
  localparam int unsigned BW_STRB = BW_DATA / 8;

  logic [BW_AXI_TID-1:0] awid;
  logic [BW_ADDR-1:0]    awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [BW_AXI_TID-1:0] wid;
  logic [BW_DATA-1:0]    wdata;
  logic [BW_STRB-1:0]    wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [BW_AXI_TID-1:0] bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/dram_write_burst_gather.sv
// Store-and-forward write stage: buffers a whole AXI write burst, then issues AW and an
// unbroken W stream to the DRAM side and relays the B response upstream.
module dram_write_burst_gather #(
  parameter int unsigned BW_ADDR    = 32,
  parameter int unsigned BW_DATA    = 128,
  parameter int unsigned BW_AXI_TID = 16,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  dram_write_burst_gather_if.slave   sx,
  dram_write_burst_gather_if.master  mx
);
  localparam int unsigned BW_STRB = BW_DATA / 8;
  localparam int unsigned BW_MEM  = BW_DATA + BW_STRB;
  localparam int unsigned BW_CNT  = $clog2(256) + 1;
  localparam int unsigned BW_PTR  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] COLLECT  = 3'd1;
  localparam logic [2:0] ISSUE_AW = 3'd2;
  localparam logic [2:0] DRAIN_W  = 3'd3;
  localparam logic [2:0] WAIT_B   = 3'd4;
  localparam logic [2:0] RESP     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [BW_AXI_TID-1:0] id_q, id_d;
  logic [BW_ADDR-1:0]    addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [BW_CNT-1:0]     cnt_q, cnt_d;
  logic [7:0]            rptr_q, rptr_d;
  logic                  err_q, err_d;
  logic                  drop_q, drop_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  mem_we;
  logic                  last_beat;

  logic sxawready_q, sxwready_q, mxawvalid_q, mxwvalid_q, mxbready_q, sxbvalid_q;
  logic [BW_DATA-1:0] wdata_q;
  logic [BW_STRB-1:0] wstrb_q;
  logic               wlast_q;

  logic [BW_MEM-1:0] mem_q [MAX_BURST];

  // Next-state and datapath decode
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    rptr_d    = rptr_q;
    err_d     = err_q;
    drop_d    = drop_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    last_beat = (cnt_q == BW_CNT'(len_q));
    case (state_q)
      IDLE: begin
        if (sx.awvalid) begin
          id_d    = sx.awid;
          addr_d  = sx.awaddr;
          len_d   = sx.awlen;
          size_d  = sx.awsize;
          burst_d = sx.awburst;
          cnt_d   = '0;
          rptr_d  = '0;
          err_d   = 1'b0;
          drop_d  = (sx.awlen > 8'(MAX_BURST - 1));
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (sx.wvalid) begin
          mem_we = !drop_q;
          cnt_d  = cnt_q + BW_CNT'(1);
          if (sx.wlast != last_beat) err_d = 1'b1;
          // Collection always consumes exactly len+1 beats, regardless of wlast
          if (last_beat) begin
            if (drop_q) begin
              bresp_d = 2'b10;
              state_d = RESP;
            end else begin
              state_d = ISSUE_AW;
            end
          end
        end
      end
      ISSUE_AW: begin
        if (mx.awready) begin
          rptr_d  = '0;
          state_d = DRAIN_W;
        end
      end
      DRAIN_W: begin
        if (mx.wready) begin
          if (rptr_q == len_q) state_d = WAIT_B;
          else                 rptr_d  = rptr_q + 8'd1;
        end
      end
      WAIT_B: begin
        if (mx.bvalid) begin
          bresp_d = err_q ? 2'b10 : mx.bresp;
          state_d = RESP;
        end
      end
      RESP: begin
        if (sx.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, control flags and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      rptr_q      <= '0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      bresp_q     <= '0;
      sxawready_q <= 1'b1;
      sxwready_q  <= 1'b0;
      mxawvalid_q <= 1'b0;
      mxwvalid_q  <= 1'b0;
      mxbready_q  <= 1'b0;
      sxbvalid_q  <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      rptr_q      <= rptr_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      bresp_q     <= bresp_d;
      sxawready_q <= (state_d == IDLE);
      sxwready_q  <= (state_d == COLLECT);
      mxawvalid_q <= (state_d == ISSUE_AW);
      mxwvalid_q  <= (state_d == DRAIN_W);
      mxbready_q  <= (state_d == WAIT_B);
      sxbvalid_q  <= (state_d == RESP);
      // Prefetch the beat addressed by the next read pointer so W payload is a flop output
      {wstrb_q, wdata_q} <= mem_q[rptr_d[BW_PTR-1:0]];
      wlast_q     <= (rptr_d == len_d);
    end
  end

  // Beat buffer, not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cnt_q[BW_PTR-1:0]] <= {sx.wstrb, sx.wdata};
  end

  assign sx.awready = sxawready_q;
  assign sx.wready  = sxwready_q;
  assign sx.bvalid  = sxbvalid_q;
  assign sx.bid     = id_q;
  assign sx.bresp   = bresp_q;

  assign mx.awvalid = mxawvalid_q;
  assign mx.awid    = id_q;
  assign mx.awaddr  = addr_q;
  assign mx.awlen   = len_q;
  assign mx.awsize  = size_q;
  assign mx.awburst = burst_q;
  assign mx.wvalid  = mxwvalid_q;
  assign mx.wid     = id_q;
  assign mx.wdata   = wdata_q;
  assign mx.wstrb   = wstrb_q;
  assign mx.wlast   = wlast_q;
  assign mx.bready  = mxbready_q;

  // Upstream W id and downstream B id are intentionally ignored
  logic unused_ids;
  assign unused_ids = ^{sx.wid, mx.bid};
endmodule

// File: tb/tb_dram_write_burst_gather.sv
// Bench for dram_write_burst_gather: directed vector table plus randomized bursts, with a
// downstream DRAM slave/memory model and a burst-level response model.
module tb_dram_write_burst_gather;
  localparam int unsigned BW_ADDR    = 32;
  localparam int unsigned BW_DATA    = 128;
  localparam int unsigned BW_AXI_TID = 16;
  localparam int unsigned MAX_BURST  = 16;
  localparam int unsigned BW_STRB    = BW_DATA / 8;

  typedef struct {
    logic [15:0] id;
    logic [31:0] addr;
    logic [7:0]  len;
    int          bad_beat;
    logic [1:0]  dn_resp;
    int          up_gap;
    int          dn_stall;
    int          b_hold;
    int          rst_beat;
    bit          full_strb;
    logic [1:0]  exp_resp;
    bit          exp_fwd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dram_write_burst_gather_if #(.BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_AXI_TID(BW_AXI_TID)) sx_if ();
  dram_write_burst_gather_if #(.BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_AXI_TID(BW_AXI_TID)) mx_if ();

  dram_write_burst_gather #(
    .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_AXI_TID(BW_AXI_TID), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sx (sx_if),
    .mx (mx_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [BW_DATA-1:0] wd [0:255];
  logic [BW_STRB-1:0] ws [0:255];
  bit                 wl [0:255];
  logic [BW_DATA-1:0] sdram_d [int];
  logic [BW_STRB-1:0] sdram_s [int];

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sx_if.awvalid = 1'b0; sx_if.wvalid = 1'b0; sx_if.bready = 1'b0;
    mx_if.awready = 1'b0; mx_if.wready = 1'b0; mx_if.bvalid = 1'b0;
    mx_if.bid = '0; mx_if.bresp = '0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awready"}, 128'(sx_if.awready), 128'(1));
    chk({tag, "_valids"},
        128'({sx_if.wready, sx_if.bvalid, mx_if.awvalid, mx_if.wvalid, mx_if.bready}), 128'(0));
  endtask

  function automatic vec_t mk(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input int bad, input logic [1:0] resp, input int gap, input int stall,
                              input int hold, input int rstb, input bit fs,
                              input logic [1:0] exp_resp, input bit exp_fwd);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.bad_beat = bad; v.dn_resp = resp;
    v.up_gap = gap; v.dn_stall = stall; v.b_hold = hold; v.rst_beat = rstb; v.full_strb = fs;
    v.exp_resp = exp_resp; v.exp_fwd = exp_fwd;
    return v;
  endfunction

  // Burst-level outcome: oversize bursts are swallowed, any wlast misplacement is SLVERR
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit oversize = (int'(v.len) >= int'(MAX_BURST));
    bit proto    = (v.bad_beat >= 0) && (v.bad_beat <= int'(v.len));
    r.exp_fwd  = !oversize;
    r.exp_resp = (oversize || proto) ? 2'b10 : v.dn_resp;
    return r;
  endfunction

  task automatic run_burst(input vec_t v, input int idx);
    int n = int'(v.len) + 1;
    bit aw_done = 0, dn_aw = 0, dn_b = 0, up_b = 0, b_seen = 0, aborted = 0, ts_ok;
    int up_beats = 0, dn_beats = 0, aw_c = -1, mxaw_t = -1, sxb_t = -1, hold = 0;
    int bubbles = 0, order_err = 0, mxaw_vis = 0, stable_err = 0, block_err = 0, rb_err = 0;
    logic [15:0] bid_first = '0;
    logic [1:0]  bresp_first = '0;
    string tag = $sformatf("v%0d", idx);
    for (int i = 0; i < n; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom};
      ws[i] = v.full_strb ? '1 : BW_STRB'($urandom);
      wl[i] = (i == n - 1);
      if (i == v.bad_beat) wl[i] = !wl[i];
    end
    for (int c = 0; c < 3000 && !up_b && !aborted; c++) begin
      if (v.rst_beat >= 0 && dn_beats == v.rst_beat) begin
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_outputs({tag, "_midrst"});
        aborted = 1;
        break;
      end
      // Upstream master
      sx_if.awvalid = 1'b0; sx_if.wvalid = 1'b0; sx_if.bready = 1'b0;
      sx_if.awid = v.id; sx_if.awaddr = v.addr; sx_if.awlen = v.len;
      sx_if.awsize = 3'd4; sx_if.awburst = 2'b01;
      if (!aw_done) sx_if.awvalid = 1'b1;
      else if (up_beats < n) begin
        sx_if.wvalid = (int'($urandom_range(99)) >= v.up_gap);
        sx_if.wid = 16'($urandom); sx_if.wdata = wd[up_beats];
        sx_if.wstrb = ws[up_beats]; sx_if.wlast = wl[up_beats];
      end
      if (sx_if.bvalid) begin
        if (!b_seen) begin
          b_seen = 1; sxb_t = c - aw_c; bid_first = sx_if.bid; bresp_first = sx_if.bresp;
        end
        if (hold < v.b_hold) begin
          hold++;
          sx_if.awvalid = 1'b1;
          if (sx_if.awready) block_err++;
        end else sx_if.bready = 1'b1;
      end
      if (b_seen && (!sx_if.bvalid || sx_if.bid !== bid_first || sx_if.bresp !== bresp_first))
        stable_err++;
      // Downstream DRAM slave
      mx_if.awready = (v.dn_stall == 0) || (int'($urandom_range(99)) >= v.dn_stall);
      mx_if.wready  = (v.dn_stall == 0) || (int'($urandom_range(99)) >= v.dn_stall);
      mx_if.bvalid  = 1'b0;
      if (dn_beats == n && !dn_b) begin
        mx_if.bvalid = 1'b1; mx_if.bresp = v.dn_resp; mx_if.bid = 16'($urandom);
      end
      // Evaluate the handshakes that complete at the coming edge
      if (mx_if.awvalid) mxaw_vis++;
      if (mx_if.wvalid && !dn_aw) order_err++;
      if (dn_aw && dn_beats < n && !mx_if.wvalid) bubbles++;
      if (mx_if.awvalid && mx_if.awready && !dn_aw) begin
        dn_aw = 1; mxaw_t = c - aw_c;
        chk({tag, "_mxawid"},   128'(mx_if.awid), 128'(v.id));
        chk({tag, "_mxawaddr"}, 128'(mx_if.awaddr), 128'(v.addr));
        chk({tag, "_mxawlen"},  128'(mx_if.awlen), 128'(v.len));
        chk({tag, "_mxawsb"},   128'({mx_if.awsize, mx_if.awburst}), 128'({3'd4, 2'b01}));
      end
      if (mx_if.wvalid && mx_if.wready) begin
        if (dn_beats < n) begin
          chk({tag, $sformatf("_wdata%0d", dn_beats)}, 128'(mx_if.wdata), 128'(wd[dn_beats]));
          chk({tag, $sformatf("_wsl%0d", dn_beats)}, 128'({mx_if.wstrb, mx_if.wlast, mx_if.wid}),
              128'({ws[dn_beats], dn_beats == n - 1, v.id}));
          sdram_d[int'(v.addr >> 4) + dn_beats] = mx_if.wdata;
          sdram_s[int'(v.addr >> 4) + dn_beats] = mx_if.wstrb;
        end else order_err++;
        dn_beats++;
      end
      if (mx_if.bvalid && mx_if.bready) dn_b = 1;
      if (sx_if.awvalid && sx_if.awready && !aw_done) begin aw_done = 1; aw_c = c; end
      if (sx_if.wvalid && sx_if.wready) up_beats++;
      if (sx_if.bvalid && sx_if.bready) up_b = 1;
      step();
    end
    idle_inputs();
    if (aborted) return;
    if (!up_b) begin
      chk({tag, "_timeout"}, 128'(0), 128'(1));
      return;
    end
    chk({tag, "_sxbresp"}, 128'(bresp_first), 128'(v.exp_resp));
    chk({tag, "_sxbid"}, 128'(bid_first), 128'(v.id));
    chk({tag, "_beats_in"}, 128'(up_beats), 128'(n));
    chk({tag, "_fwd"}, 128'(mxaw_vis != 0), 128'(v.exp_fwd));
    chk({tag, "_bstable"}, 128'(stable_err), 128'(0));
    if (v.b_hold > 0) chk({tag, "_awblock"}, 128'(block_err), 128'(0));
    if (v.exp_fwd) begin
      chk({tag, "_beats_out"}, 128'(dn_beats), 128'(n));
      chk({tag, "_bubble"}, 128'({bubbles, order_err}), 128'(0));
      for (int i = 0; i < n; i++) begin
        ts_ok = sdram_d.exists(int'(v.addr >> 4) + i);
        if (!ts_ok || sdram_d[int'(v.addr >> 4) + i] !== wd[i] ||
            sdram_s[int'(v.addr >> 4) + i] !== ws[i]) rb_err++;
      end
      chk({tag, "_readback"}, 128'(rb_err), 128'(0));
    end
    if (v.up_gap == 0 && v.dn_stall == 0 && v.b_hold == 0) begin
      if (v.exp_fwd) chk({tag, "_t_mxaw"}, 128'(mxaw_t), 128'(n + 1));
      chk({tag, "_t_sxb"}, 128'(sxb_t), 128'(v.exp_fwd ? 2 * int'(v.len) + 5 : int'(v.len) + 2));
    end
    // Next AW window opens the cycle after the B handshake
    chk({tag, "_b2b"}, 128'({sx_if.awready, sx_if.bvalid}), 128'(2'b10));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    sx_if.awid = '0; sx_if.awaddr = '0; sx_if.awlen = '0; sx_if.awsize = '0; sx_if.awburst = '0;
    sx_if.wid = '0; sx_if.wdata = '0; sx_if.wstrb = '0; sx_if.wlast = 1'b0;
    idle_inputs();
    //            id       addr          len   bad resp gap stl hold rst fs  exp   fwd
    vecs.push_back(mk(16'h0011, 32'h0000_0100, 8'd0,  -1, 2'b00, 0, 0, 0, -1, 1, 2'b00, 1));
    vecs.push_back(mk(16'h0022, 32'h0000_1000, 8'd15, -1, 2'b00, 30, 40, 0, -1, 0, 2'b00, 1));
    vecs.push_back(mk(16'h0033, 32'h0000_2000, 8'd16, -1, 2'b00, 0, 0, 0, -1, 0, 2'b10, 0));
    vecs.push_back(mk(16'h0044, 32'h0000_3000, 8'd3,   1, 2'b00, 0, 0, 0, -1, 0, 2'b10, 1));
    vecs.push_back(mk(16'h00A5, 32'h0000_4000, 8'd2,  -1, 2'b01, 0, 0, 4, -1, 0, 2'b01, 1));
    vecs.push_back(mk(16'h0055, 32'h0000_5000, 8'd7,  -1, 2'b00, 0, 0, 0,  2, 0, 2'b00, 1));
    vecs.push_back(mk(16'h0066, 32'h0000_6000, 8'd5,  -1, 2'b00, 0, 0, 0, -1, 0, 2'b00, 1));
    vecs.push_back(mk(16'h0077, 32'h0000_7000, 8'd15, -1, 2'b11, 0, 0, 0, -1, 0, 2'b11, 1));
    for (int i = 0; i < 14; i++) begin
      vec_t r;
      logic [7:0] len = 8'($urandom_range(17));
      r = mk(16'($urandom), {16'($urandom), 12'($urandom), 4'h0}, len,
             ($urandom_range(3) == 0) ? int'($urandom_range(int'(len))) : -1,
             2'($urandom), int'($urandom_range(50)), int'($urandom_range(50)),
             int'($urandom_range(3)), -1, 0, 2'b00, 0);
      vecs.push_back(model(r));
    end
    repeat (3) step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();
    chk_idle_outputs("post_reset");
    foreach (vecs[i]) run_burst(vecs[i], i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
